// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU and debug requesters, the data-memory arbiter and the RAM.
// The arbiter uses the slave view; the environment (CPU, loader, RAM) uses the master view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic [1:0]    we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  logic          cpu_stall;

  logic          req1;
  logic [1:0]    we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          mem_en;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0, cpu_stall,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0, cpu_stall,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and debug/loader (port 1) accesses onto one synchronous data RAM.
// Build option ARB_ROUND_ROBIN_EN: alternate ties between ports; otherwise the CPU wins ties.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_r;
  logic   winner_r;
  logic   last_r;
  logic   any_req_s;
  logic   grant_s;

  // Stall the CPU while its request is outstanding and not yet acknowledged.
  assign bus.cpu_stall = bus.req0 & ~bus.ack0;

  // Pick the port to serve from the requests visible this cycle.
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    grant_s   = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_s = ~last_r;
`else
      // Fixed priority: the pointer is still tracked but never steers a tie.
      grant_s = last_r & 1'b0;
`endif
    end else if (bus.req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Access sequencer: latch command, pulse RAM enable, return ack/data, release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      winner_r      <= 1'b0;
      last_r        <= 1'b1;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 2'b00;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata0    <= {DW{1'b0}};
      bus.rdata1    <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            winner_r      <= grant_s;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_s ? bus.we1    : bus.we0;
            bus.mem_addr  <= grant_s ? bus.addr1  : bus.addr0;
            bus.mem_wdata <= grant_s ? bus.wdata1 : bus.wdata0;
            state_r       <= ACCESS;
          end else begin
            bus.mem_en <= 1'b0;
            state_r    <= IDLE;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 2'b00;
          // Read data is captured only for loads; stores leave rdata untouched.
          if (winner_r) begin
            bus.ack1 <= 1'b1;
            if (bus.mem_we == 2'b00) begin
              bus.rdata1 <= bus.mem_rdata;
            end else begin
              bus.rdata1 <= bus.rdata1;
            end
          end else begin
            bus.ack0 <= 1'b1;
            if (bus.mem_we == 2'b00) begin
              bus.rdata0 <= bus.mem_rdata;
            end else begin
              bus.rdata0 <= bus.rdata0;
            end
          end
          state_r <= RESP;
        end
        RESP: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          last_r   <= winner_r;
          state_r  <= IDLE;
        end
        default: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 2'b00;
          bus.ack0   <= 1'b0;
          bus.ack1   <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
